// File: rtl/writeback_unit.sv
// Commit stage after execute. It captures one execute result per ex_valid
// pulse and commits the register-file, SREG and PC updates in a single cycle.
// An optional handshaked data-memory write follows the commit cycle. wb_done
// pulses once the instruction has fully retired.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for ex_valid; captures all execute outputs on it
// COMMIT | one cycle: rf_we / sreg_we / pc_we strobes
// MEM    | mem_req held until mem_ack or timeout
// DONE   | one cycle: wb_done retire pulse
module writeback_unit #(
  parameter int WORD        = 16,
  parameter int RCODE       = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             reg_wb,
  input  logic [RCODE-1:0] reg_write_code,
  input  logic [WORD-1:0]  reg_write_val,
  input  logic             mem_wb,
  input  logic [WORD-1:0]  mem_write_addr,
  input  logic [WORD-1:0]  mem_write_val,
  input  logic             flag_update,
  input  logic [WORD-1:0]  SREG_out,
  input  logic             jump,
  input  logic             rjump,
  input  logic [WORD-1:0]  PC_jump_loc,
  input  logic [WORD-1:0]  PC_jump_inc,
  input  logic [WORD-1:0]  pc_cur,
  input  logic [1:0]       instr_len,
  output logic             rf_we,
  output logic [RCODE-1:0] rf_waddr,
  output logic [WORD-1:0]  rf_wdata,
  output logic             sreg_we,
  output logic [WORD-1:0]  sreg_q,
  output logic             pc_we,
  output logic [WORD-1:0]  pc_next,
  output logic             mem_req,
  output logic [WORD-1:0]  mem_addr,
  output logic [WORD-1:0]  mem_wdata,
  input  logic             mem_ack,
  output logic             wb_done,
  output logic             busy,
  output logic             mem_err,
  output logic             ovr_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_MEM    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter only needs to reach MEM_TIMEOUT-1; the last MEM cycle is the compare cycle.
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             reg_wb_q, reg_wb_d;
  logic             flag_q, flag_d;
  logic             mem_wb_q, mem_wb_d;
  logic [RCODE-1:0] rf_waddr_q, rf_waddr_d;
  logic [WORD-1:0]  rf_wdata_q, rf_wdata_d;
  logic [WORD-1:0]  sreg_val_q, sreg_val_d;
  logic [WORD-1:0]  pc_next_q, pc_next_d;
  logic [WORD-1:0]  mem_addr_q, mem_addr_d;
  logic [WORD-1:0]  mem_wdata_q, mem_wdata_d;
  logic             mem_err_q, mem_err_d;
  logic             ovr_err_q, ovr_err_d;
  logic [WORD-1:0]  len_ext;
  logic [WORD-1:0]  pc_calc;

  // Next PC from the incoming result; instr_len 0 and 3 fall back to one word.
  always_comb begin
    len_ext = (instr_len == 2'd2) ? WORD'(2) : WORD'(1);
    if (jump)       pc_calc = PC_jump_loc;
    else if (rjump) pc_calc = pc_cur + PC_jump_inc;
    else            pc_calc = pc_cur + len_ext;
  end

  // Sequencer next-state, capture of execute results and error tracking.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_wb_d    = reg_wb_q;
    flag_d      = flag_q;
    mem_wb_d    = mem_wb_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    sreg_val_d  = sreg_val_q;
    pc_next_d   = pc_next_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = mem_err_q;
    ovr_err_d   = ovr_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          reg_wb_d  = reg_wb;
          flag_d    = flag_update;
          mem_wb_d  = mem_wb;
          pc_next_d = pc_calc;
          // Buses only move when their write is actually performed.
          if (reg_wb) begin
            rf_waddr_d = reg_write_code;
            rf_wdata_d = reg_write_val;
          end
          if (flag_update) sreg_val_d = SREG_out;
          if (mem_wb) begin
            mem_addr_d  = mem_write_addr;
            mem_wdata_d = mem_write_val;
          end
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        cnt_d   = '0;
        state_d = mem_wb_q ? S_MEM : S_DONE;
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A result arriving while a previous one is still retiring is lost.
    if (ex_valid && (state_q != S_IDLE)) ovr_err_d = 1'b1;
  end

  // State and holding registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      reg_wb_q    <= 1'b0;
      flag_q      <= 1'b0;
      mem_wb_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      sreg_val_q  <= '0;
      pc_next_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_wb_q    <= reg_wb_d;
      flag_q      <= flag_d;
      mem_wb_q    <= mem_wb_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      sreg_val_q  <= sreg_val_d;
      pc_next_q   <= pc_next_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  assign rf_we     = (state_q == S_COMMIT) & reg_wb_q;
  assign sreg_we   = (state_q == S_COMMIT) & flag_q;
  assign pc_we     = (state_q == S_COMMIT);
  assign mem_req   = (state_q == S_MEM);
  assign wb_done   = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign sreg_q    = sreg_val_q;
  assign pc_next   = pc_next_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_err   = mem_err_q;
  assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: expected commits are queued when a result is
// driven and compared when the commit strobe appears.
module tb_writeback_unit;

  localparam int WORD        = 16;
  localparam int RCODE       = 3;
  localparam int MEM_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, reg_wb, mem_wb, flag_update, jump, rjump, mem_ack;
  logic [RCODE-1:0] reg_write_code;
  logic [WORD-1:0]  reg_write_val, mem_write_addr, mem_write_val, SREG_out;
  logic [WORD-1:0]  PC_jump_loc, PC_jump_inc, pc_cur;
  logic [1:0]       instr_len;
  logic             rf_we, sreg_we, pc_we, mem_req, wb_done, busy, mem_err, ovr_err;
  logic [RCODE-1:0] rf_waddr;
  logic [WORD-1:0]  rf_wdata, sreg_q, pc_next, mem_addr, mem_wdata;

  writeback_unit #(.WORD(WORD), .RCODE(RCODE), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .reg_wb(reg_wb), .reg_write_code(reg_write_code), .reg_write_val(reg_write_val),
    .mem_wb(mem_wb), .mem_write_addr(mem_write_addr), .mem_write_val(mem_write_val),
    .flag_update(flag_update), .SREG_out(SREG_out),
    .jump(jump), .rjump(rjump), .PC_jump_loc(PC_jump_loc), .PC_jump_inc(PC_jump_inc),
    .pc_cur(pc_cur), .instr_len(instr_len),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sreg_we(sreg_we), .sreg_q(sreg_q), .pc_we(pc_we), .pc_next(pc_next),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .wb_done(wb_done), .busy(busy), .mem_err(mem_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        reg_wb;
    logic [2:0]  code;
    logic [15:0] rval;
    logic        mem_wb;
    logic [15:0] maddr;
    logic [15:0] mval;
    logic        flag;
    logic [15:0] sreg;
    logic        jump;
    logic        rjump;
    logic [15:0] loc;
    logic [15:0] inc;
    logic [15:0] pc;
    logic [1:0]  len;
  } instr_t;

  typedef struct packed {
    logic        rf_we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        sreg_we;
    logic [15:0] sreg;
    logic [15:0] pc;
    logic        mem;
    logic [15:0] maddr;
    logic [15:0] mdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_mem_err = 1'b0;
  logic exp_ovr_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pc(input instr_t i);
    logic [15:0] step;
    step = (i.len == 2'd2) ? 16'd2 : 16'd1;
    if (i.jump)  return i.loc;
    if (i.rjump) return 16'(i.pc + i.inc);
    return 16'(i.pc + step);
  endfunction

  task automatic drive_inputs(input instr_t i);
    reg_wb = i.reg_wb; reg_write_code = i.code; reg_write_val = i.rval;
    mem_wb = i.mem_wb; mem_write_addr = i.maddr; mem_write_val = i.mval;
    flag_update = i.flag; SREG_out = i.sreg;
    jump = i.jump; rjump = i.rjump; PC_jump_loc = i.loc; PC_jump_inc = i.inc;
    pc_cur = i.pc; instr_len = i.len;
  endtask

  task automatic scramble_inputs();
    instr_t r;
    r = instr_t'({$urandom, $urandom, $urandom, $urandom});
    drive_inputs(r);
  endtask

  // Runs one instruction from an IDLE negedge through retirement.
  // ack_at: MEM cycle in which mem_ack is raised (-1 = never, i.e. timeout).
  task automatic do_instr(input instr_t i, input int ack_at,
                          input bit inject_ovr, input bit rst_in_mem);
    exp_t e;
    int   n;
    e.rf_we = i.reg_wb;  e.waddr = i.code;  e.wdata = i.rval;
    e.sreg_we = i.flag;  e.sreg = i.sreg;   e.pc = model_pc(i);
    e.mem = i.mem_wb;    e.maddr = i.maddr; e.mdata = i.mval;
    drive_inputs(i);
    ex_valid = 1'b1;
    sb.push_back(e);

    @(negedge clk);
    ex_valid = 1'b0;
    scramble_inputs();
    mem_ack = 1'b1;
    chk("pc_we", pc_we, 1'b1);
    chk("busy_commit", busy, 1'b1);
    chk("mem_req_commit", mem_req, 1'b0);
    chk("wb_done_commit", wb_done, 1'b0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rf_we", rf_we, e.rf_we);
      if (e.rf_we) begin
        chk("rf_waddr", rf_waddr, e.waddr);
        chk("rf_wdata", rf_wdata, e.wdata);
      end
      chk("sreg_we", sreg_we, e.sreg_we);
      if (e.sreg_we) chk("sreg_q", sreg_q, e.sreg);
      chk("pc_next", pc_next, e.pc);
    end

    @(negedge clk);
    mem_ack = 1'b0;
    chk("pc_we_pulse", pc_we, 1'b0);
    if (e.mem) begin
      n = 0;
      while (mem_req && n < 40) begin
        n++;
        chk("mem_addr", mem_addr, e.maddr);
        chk("mem_wdata", mem_wdata, e.mdata);
        if (inject_ovr && n == 1) ex_valid = 1'b1;
        if (rst_in_mem && n == 2) begin
          rst = 1'b1;
          break;
        end
        mem_ack = (n == ack_at);
        @(negedge clk);
        mem_ack = 1'b0;
        ex_valid = 1'b0;
      end
      if (inject_ovr) exp_ovr_err = 1'b1;
      if (rst_in_mem) begin
        @(negedge clk);
        rst = 1'b0;
        exp_mem_err = 1'b0;
        exp_ovr_err = 1'b0;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_buses", {rf_wdata, pc_next}, 32'h0);
        chk("rst_buses2", {sreg_q, mem_addr}, 32'h0);
        chk("rst_misc", {mem_wdata, 5'b0, rf_waddr, rf_we, sreg_we, pc_we, wb_done, mem_err, ovr_err},
            32'h0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("rst_no_done", wb_done | pc_we | mem_req, 1'b0);
        end
        return;
      end
      if (ack_at < 0) exp_mem_err = 1'b1;
      chk("mem_cycles", n, (ack_at > 0) ? ack_at : MEM_TIMEOUT);
    end
    chk("wb_done", wb_done, 1'b1);
    chk("mem_req_done", mem_req, 1'b0);
    chk("mem_err", mem_err, exp_mem_err);
    chk("ovr_err", ovr_err, exp_ovr_err);

    @(negedge clk);
    chk("wb_done_pulse", wb_done, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask

  instr_t ins;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; mem_ack = 1'b0;
    ins = '0;
    drive_inputs(ins);
    repeat (3) @(negedge clk);
    chk("reset_strobes", {rf_we, sreg_we, pc_we, mem_req, wb_done, busy, mem_err, ovr_err}, 8'h0);
    chk("reset_buses", {rf_wdata, pc_next}, 32'h0);
    chk("reset_buses2", {sreg_q, mem_addr}, 32'h0);
    chk("reset_buses3", {mem_wdata, 13'h0, rf_waddr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ADD r3 = 7
    ins = '0; ins.reg_wb = 1; ins.code = 3; ins.rval = 16'h0007; ins.flag = 1;
    ins.sreg = 16'h0000; ins.pc = 16'h0010; ins.len = 2'd1;
    do_instr(ins, 0, 0, 0);

    // memory write acked in the third MEM cycle
    ins = '0; ins.mem_wb = 1; ins.maddr = 16'h0040; ins.mval = 16'hBEEF;
    ins.pc = 16'h0020; ins.len = 2'd2;
    do_instr(ins, 3, 0, 0);

    // jump priority, then relative jump alone
    ins = '0; ins.jump = 1; ins.rjump = 1; ins.loc = 16'h0100; ins.inc = 16'hFFFE; ins.pc = 16'h0020;
    do_instr(ins, 0, 0, 0);
    ins.jump = 0;
    do_instr(ins, 0, 0, 0);

    // wraparound cases
    ins = '0; ins.pc = 16'hFFFF; ins.len = 2'd2;
    do_instr(ins, 0, 0, 0);
    ins = '0; ins.rjump = 1; ins.inc = 16'h0003; ins.pc = 16'hFFFE;
    do_instr(ins, 0, 0, 0);

    // odd instruction lengths advance by one
    ins = '0; ins.pc = 16'h1230; ins.len = 2'd0; ins.flag = 1; ins.sreg = 16'h00A5;
    do_instr(ins, 0, 0, 0);
    ins.len = 2'd3;
    do_instr(ins, 0, 0, 0);

    // register and memory write together, ack in the first MEM cycle
    ins = '0; ins.reg_wb = 1; ins.code = 5; ins.rval = 16'h1234; ins.mem_wb = 1;
    ins.maddr = 16'h0F00; ins.mval = 16'h5A5A; ins.pc = 16'h0300; ins.len = 2'd1;
    do_instr(ins, 1, 0, 0);

    // timeout: mem_ack never arrives
    ins = '0; ins.mem_wb = 1; ins.maddr = 16'h0080; ins.mval = 16'hCAFE; ins.pc = 16'h0400;
    do_instr(ins, -1, 0, 0);

    // overrun during MEM, then confirm no extra commit follows
    ins = '0; ins.mem_wb = 1; ins.maddr = 16'h0090; ins.mval = 16'h7777; ins.pc = 16'h0500;
    ins.reg_wb = 1; ins.code = 1; ins.rval = 16'h0101;
    do_instr(ins, 2, 1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_extra_commit", pc_we | busy, 1'b0);
    end

    // error flags stay set across a clean instruction
    ins = '0; ins.pc = 16'h0600; ins.len = 2'd1;
    do_instr(ins, 0, 0, 0);

    // reset during MEM aborts the write
    ins = '0; ins.mem_wb = 1; ins.maddr = 16'h00A0; ins.mval = 16'h4321; ins.pc = 16'h0700;
    do_instr(ins, 5, 0, 1);

    // a few randomised instructions
    for (int k = 0; k < 8; k++) begin
      ins = instr_t'({$urandom, $urandom, $urandom, $urandom});
      do_instr(ins, int'($urandom_range(1, 4)), 0, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
